captura_tiempo_rtc: RTL and testbench

Upstream stage of the remaining-time subtractor. It captures the BCD seconds/minutes/hours timer bytes returned by the RTC read sequencer, one byte per strobe, into shadow registers. It validates each byte as legal BCD within range and commits a coherent h/m/s snapshot atomically. The snapshot drives hora_out/minuto_out/segundo_out, which connect directly to the subtractor's hora_in/minuto_in/segundo_in.

---
 rtl/captura_tiempo_rtc_pkg.sv | 29 ++
 rtl/captura_tiempo_rtc_valida_bcd.sv | 20 ++
 rtl/captura_tiempo_rtc.sv | 141 ++++++++++++++
 tb/tb_captura_tiempo_rtc.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/captura_tiempo_rtc_pkg.sv
// Shared constants for the RTC time capture stage: RTC register addresses,
// BCD range limits, frame timeout and the capture FSM encoding.
package captura_tiempo_rtc_pkg;

    localparam logic [7:0]  DIR_SEG     = 8'h41;
    localparam logic [7:0]  DIR_MIN     = 8'h42;
    localparam logic [7:0]  DIR_HORA    = 8'h43;

    localparam logic [7:0]  LIM_HORA    = 8'h23;
    localparam logic [7:0]  LIM_MIN_SEG = 8'h59;

    localparam logic [15:0] TIMEOUT     = 16'd1000;
    localparam logic [15:0] TIMEOUT_ULT = TIMEOUT - 16'd1;

    // Bit positions of each field inside the frame mask.
    localparam int BIT_SEG  = 0;
    localparam int BIT_MIN  = 1;
    localparam int BIT_HORA = 2;

    localparam logic [2:0]  MASCARA_LLENA = 3'b111;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        CAPTURA   = 2'd1,
        PENDIENTE = 2'd2,
        ACTUALIZA = 2'd3
    } estado_t;

endpackage

// File: rtl/captura_tiempo_rtc_valida_bcd.sv
// Combinational legality check of one RTC byte: both nibbles decimal and the
// value within 00..23 (hours) or 00..59 (minutes/seconds).
module captura_tiempo_rtc_valida_bcd
    import captura_tiempo_rtc_pkg::*;
(
    input  logic [7:0] dato,
    input  logic       es_hora,
    output logic       ok
);

    logic       nibbles_ok;
    logic [7:0] limite;

    assign nibbles_ok = (dato[7:4] <= 4'd9) && (dato[3:0] <= 4'd9);
    assign limite     = es_hora ? LIM_HORA : LIM_MIN_SEG;

    // Once both nibbles are decimal, a plain binary compare orders BCD values.
    assign ok = nibbles_ok && (dato <= limite);

endmodule

// File: rtl/captura_tiempo_rtc.sv
// Captures the RTC seconds/minutes/hours bytes into shadow registers and
// commits a coherent h:m:s snapshot to the subtractor inputs in one cycle.
module captura_tiempo_rtc
    import captura_tiempo_rtc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio_rafaga,
    input  logic       strobe_lectura,
    input  logic [7:0] dir_rtc,
    input  logic [7:0] dato_rtc,
    input  logic       congelar,
    output logic [7:0] hora_out,
    output logic [7:0] minuto_out,
    output logic [7:0] segundo_out,
    output logic       actualizado,
    output logic       error_bcd,
    output logic       error_timeout
);

    // strobe_lectura qualifies dir_rtc/dato_rtc for exactly one cycle. There is
    // no backpressure: bytes offered while a complete frame waits or commits are dropped.

    estado_t     estado, estado_sig, estado_ef;
    logic [2:0]  mascara, mascara_sig, mascara_ef, bit_dir;
    logic [15:0] contador, contador_sig;
    logic [7:0]  sh_seg, sh_min, sh_hora;
    logic        dir_valida, byte_ok, escribe, err_bcd_sig, err_to_sig, carga;

    assign bit_dir    = {dir_rtc == DIR_HORA, dir_rtc == DIR_MIN, dir_rtc == DIR_SEG};
    assign dir_valida = strobe_lectura && (bit_dir != 3'b000);
    assign carga      = (estado_sig == ACTUALIZA);

    captura_tiempo_rtc_valida_bcd u_valida_bcd (
        .dato    (dato_rtc),
        .es_hora (bit_dir[BIT_HORA]),
        .ok      (byte_ok)
    );

    always_comb begin
        estado_ef    = estado;
        mascara_ef   = mascara;
        contador_sig = contador;
        // A new burst wipes the frame before this cycle's byte is considered.
        if (inicio_rafaga && (estado != ACTUALIZA)) begin
            estado_ef    = REPOSO;
            mascara_ef   = 3'b000;
            contador_sig = 16'd0;
        end
        estado_sig  = estado_ef;
        mascara_sig = mascara_ef;
        escribe     = 1'b0;
        err_bcd_sig = 1'b0;
        err_to_sig  = 1'b0;

        case (estado_ef)
            REPOSO: begin
                if (dir_valida) begin
                    if (byte_ok) begin
                        escribe      = 1'b1;
                        mascara_sig  = bit_dir;
                        contador_sig = 16'd0;
                        estado_sig   = CAPTURA;
                    end else begin
                        err_bcd_sig  = 1'b1;
                    end
                end
            end
            CAPTURA: begin
                if (mascara_ef == MASCARA_LLENA) begin
                    estado_sig = congelar ? PENDIENTE : ACTUALIZA;
                end else begin
                    contador_sig = contador + 16'd1;
                    if (dir_valida && !byte_ok) begin
                        err_bcd_sig = 1'b1;
                        mascara_sig = 3'b000;
                        estado_sig  = REPOSO;
                    end else begin
                        if (dir_valida) begin
                            escribe     = 1'b1;
                            mascara_sig = mascara_ef | bit_dir;
                        end
                        // A byte completing the frame on the deadline cycle still saves it.
                        if ((contador == TIMEOUT_ULT) && (mascara_sig != MASCARA_LLENA)) begin
                            err_to_sig  = 1'b1;
                            mascara_sig = 3'b000;
                            estado_sig  = REPOSO;
                        end
                    end
                end
            end
            PENDIENTE: begin
                if (!congelar) begin
                    estado_sig = ACTUALIZA;
                end
            end
            ACTUALIZA: begin
                mascara_sig = 3'b000;
                estado_sig  = REPOSO;
            end
            default: begin
                mascara_sig = 3'b000;
                estado_sig  = REPOSO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado        <= REPOSO;
            mascara       <= 3'b000;
            contador      <= 16'd0;
            sh_seg        <= 8'h00;
            sh_min        <= 8'h00;
            sh_hora       <= 8'h00;
            hora_out      <= 8'h00;
            minuto_out    <= 8'h00;
            segundo_out   <= 8'h00;
            actualizado   <= 1'b0;
            error_bcd     <= 1'b0;
            error_timeout <= 1'b0;
        end else begin
            estado        <= estado_sig;
            mascara       <= mascara_sig;
            contador      <= contador_sig;
            actualizado   <= carga;
            error_bcd     <= err_bcd_sig;
            error_timeout <= err_to_sig;
            if (escribe && bit_dir[BIT_SEG])  sh_seg  <= dato_rtc;
            if (escribe && bit_dir[BIT_MIN])  sh_min  <= dato_rtc;
            if (escribe && bit_dir[BIT_HORA]) sh_hora <= dato_rtc;
            // All three outputs move together, only on entry to ACTUALIZA.
            if (carga) begin
                hora_out    <= sh_hora;
                minuto_out  <= sh_min;
                segundo_out <= sh_seg;
            end
        end
    end

endmodule

// File: tb/tb_captura_tiempo_rtc.sv
// Directed bench for captura_tiempo_rtc: frame-level reference model checked
// every cycle, commit snapshots scoreboarded, plus literal expectations.
`timescale 1ns/1ps
module tb_captura_tiempo_rtc;

    localparam int T_OUT = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       inicio_rafaga = 1'b0;
    logic       strobe_lectura = 1'b0;
    logic       congelar = 1'b0;
    logic [7:0] dir_rtc = 8'h00;
    logic [7:0] dato_rtc = 8'h00;
    logic [7:0] hora_out, minuto_out, segundo_out;
    logic       actualizado, error_bcd, error_timeout;

    int n_cmp = 0;
    int n_fail = 0;

    captura_tiempo_rtc dut (
        .clk            (clk),
        .reset          (reset),
        .inicio_rafaga  (inicio_rafaga),
        .strobe_lectura (strobe_lectura),
        .dir_rtc        (dir_rtc),
        .dato_rtc       (dato_rtc),
        .congelar       (congelar),
        .hora_out       (hora_out),
        .minuto_out     (minuto_out),
        .segundo_out    (segundo_out),
        .actualizado    (actualizado),
        .error_bcd      (error_bcd),
        .error_timeout  (error_timeout)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model (frame view) ----------------
    logic [7:0]  m_h, m_m, m_s;
    logic        m_act, m_eb, m_et;
    bit          m_open;
    bit          m_got [3];
    logic [7:0]  m_val [3];
    int          m_open_cyc;
    int          cyc = 0;
    logic [23:0] exp_q [$];

    function automatic int campo(input logic [7:0] d);
        case (d)
            8'h41:   return 0;
            8'h42:   return 1;
            8'h43:   return 2;
            default: return -1;
        endcase
    endfunction

    function automatic bit legal(input logic [7:0] v, input int f);
        int hi, lo;
        hi = int'(v[7:4]);
        lo = int'(v[3:0]);
        if (hi > 9 || lo > 9) return 1'b0;
        return (hi * 10 + lo) <= ((f == 2) ? 23 : 59);
    endfunction

    function automatic bit completo();
        return m_got[0] && m_got[1] && m_got[2];
    endfunction

    task automatic cerrar();
        m_open = 1'b0;
        for (int i = 0; i < 3; i++) m_got[i] = 1'b0;
    endtask

    task automatic model_reset();
        m_h = 8'h00; m_m = 8'h00; m_s = 8'h00;
        m_act = 1'b0; m_eb = 1'b0; m_et = 1'b0;
        cerrar();
    endtask

    task automatic model_step();
        int f;
        m_eb = 1'b0;
        m_et = 1'b0;
        if (m_act) begin
            m_act = 1'b0;
            return;
        end
        if (inicio_rafaga) cerrar();
        if (m_open && completo()) begin
            if (!congelar) begin
                m_h = m_val[2]; m_m = m_val[1]; m_s = m_val[0];
                exp_q.push_back({m_val[2], m_val[1], m_val[0]});
                m_act = 1'b1;
                cerrar();
            end
            return;
        end
        f = campo(dir_rtc);
        if (strobe_lectura && f >= 0) begin
            if (legal(dato_rtc, f)) begin
                m_val[f] = dato_rtc;
                m_got[f] = 1'b1;
                if (!m_open) begin
                    m_open = 1'b1;
                    m_open_cyc = cyc;
                    return;
                end
            end else begin
                m_eb = 1'b1;
                cerrar();
                return;
            end
        end
        if (m_open && !completo() && (cyc - m_open_cyc == T_OUT)) begin
            m_et = 1'b1;
            cerrar();
        end
    endtask

    // ---------------- scoreboard / per-cycle compare ----------------
    always @(posedge clk) begin
        logic [23:0] e;
        if (!reset) model_reset();
        else begin
            cyc++;
            model_step();
        end
        #1;
        n_cmp++;
        if ({hora_out, minuto_out, segundo_out, actualizado, error_bcd, error_timeout} !==
            {m_h, m_m, m_s, m_act, m_eb, m_et}) begin
            n_fail++;
            $display("FAIL cycle_cmp @%0t: dut h=%h m=%h s=%h act=%b eb=%b et=%b, model h=%h m=%h s=%h act=%b eb=%b et=%b",
                     $time, hora_out, minuto_out, segundo_out, actualizado, error_bcd, error_timeout,
                     m_h, m_m, m_s, m_act, m_eb, m_et);
        end
        if (actualizado === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL commit_sb @%0t: actualizado with no expected snapshot, dut %h:%h:%h",
                         $time, hora_out, minuto_out, segundo_out);
            end else begin
                e = exp_q.pop_front();
                if ({hora_out, minuto_out, segundo_out} !== e) begin
                    n_fail++;
                    $display("FAIL commit_sb @%0t: got %h:%h:%h expected %h:%h:%h", $time,
                             hora_out, minuto_out, segundo_out, e[23:16], e[15:8], e[7:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_hms(input string nm, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        chk(nm, {8'h00, hora_out, minuto_out, segundo_out}, {8'h00, h, m, s});
    endtask

    task automatic byte_rtc(input logic [7:0] d, input logic [7:0] v, input logic ini);
        strobe_lectura = 1'b1;
        dir_rtc        = d;
        dato_rtc       = v;
        inicio_rafaga  = ini;
        @(negedge clk);
        strobe_lectura = 1'b0;
        inicio_rafaga  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic report();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        idle(3);
        chk_hms("reset_hms", 8'h00, 8'h00, 8'h00);
        chk("reset_flags", {29'd0, actualizado, error_bcd, error_timeout}, 32'd0);
        reset = 1'b1;
        idle(1);

        // Basic burst, one-cycle latency after the last strobe.
        byte_rtc(8'h41, 8'h30, 1'b0);
        byte_rtc(8'h42, 8'h15, 1'b0);
        byte_rtc(8'h43, 8'h09, 1'b0);
        chk_hms("burst1_not_yet", 8'h00, 8'h00, 8'h00);
        chk("burst1_act_not_yet", {31'd0, actualizado}, 32'd0);
        idle(1);
        chk_hms("burst1", 8'h09, 8'h15, 8'h30);
        chk("burst1_act", {31'd0, actualizado}, 32'd1);
        idle(1);
        chk("burst1_act_single", {31'd0, actualizado}, 32'd0);

        // Invalid bytes: bad nibble, then out-of-range hour.
        byte_rtc(8'h41, 8'h5A, 1'b0);
        chk("err_nibble", {31'd0, error_bcd}, 32'd1);
        idle(1);
        chk("err_nibble_single", {31'd0, error_bcd}, 32'd0);
        byte_rtc(8'h43, 8'h24, 1'b0);
        chk("err_hour_range", {31'd0, error_bcd}, 32'd1);
        chk_hms("err_keep", 8'h09, 8'h15, 8'h30);

        // A rejected byte discards the partial frame.
        byte_rtc(8'h41, 8'h10, 1'b0);
        byte_rtc(8'h42, 8'h20, 1'b0);
        byte_rtc(8'h43, 8'h24, 1'b0);
        chk("err_mid_frame", {31'd0, error_bcd}, 32'd1);
        byte_rtc(8'h43, 8'h05, 1'b0);
        idle(3);
        chk_hms("mask_cleared_no_commit", 8'h09, 8'h15, 8'h30);
        inicio_rafaga = 1'b1;
        idle(1);
        inicio_rafaga = 1'b0;

        // Unknown address with garbage data is ignored silently.
        byte_rtc(8'h44, 8'hFF, 1'b0);
        chk("ignored_addr", {31'd0, error_bcd}, 32'd0);

        // Out-of-order delivery at the upper limits.
        byte_rtc(8'h43, 8'h23, 1'b0);
        byte_rtc(8'h41, 8'h59, 1'b0);
        byte_rtc(8'h42, 8'h59, 1'b0);
        idle(1);
        chk_hms("out_of_order", 8'h23, 8'h59, 8'h59);
        chk("out_of_order_act", {31'd0, actualizado}, 32'd1);
        idle(1);

        // Timeout: two bytes only; error lands TIMEOUT edges after the first.
        byte_rtc(8'h41, 8'h12, 1'b0);
        byte_rtc(8'h42, 8'h34, 1'b0);
        idle(T_OUT - 2);
        chk("timeout_not_yet", {31'd0, error_timeout}, 32'd0);
        idle(1);
        chk("timeout_pulse", {31'd0, error_timeout}, 32'd1);
        chk_hms("timeout_no_commit", 8'h23, 8'h59, 8'h59);
        idle(1);
        chk("timeout_single", {31'd0, error_timeout}, 32'd0);
        byte_rtc(8'h41, 8'h45, 1'b0);
        byte_rtc(8'h42, 8'h30, 1'b0);
        byte_rtc(8'h43, 8'h12, 1'b0);
        idle(1);
        chk_hms("after_timeout", 8'h12, 8'h30, 8'h45);
        idle(1);

        // Freeze holds a complete frame until congelar drops.
        congelar = 1'b1;
        byte_rtc(8'h41, 8'h30, 1'b0);
        byte_rtc(8'h42, 8'h20, 1'b0);
        byte_rtc(8'h43, 8'h10, 1'b0);
        idle(5);
        chk_hms("frozen_hold", 8'h12, 8'h30, 8'h45);
        chk("frozen_no_act", {31'd0, actualizado}, 32'd0);
        congelar = 1'b0;
        idle(1);
        chk_hms("unfrozen", 8'h10, 8'h20, 8'h30);
        chk("unfrozen_act", {31'd0, actualizado}, 32'd1);
        idle(1);
        chk("unfrozen_act_single", {31'd0, actualizado}, 32'd0);

        // inicio_rafaga with a strobe drops the old partial frame first.
        byte_rtc(8'h42, 8'h08, 1'b0);
        byte_rtc(8'h43, 8'h09, 1'b0);
        byte_rtc(8'h41, 8'h01, 1'b1);
        idle(2);
        chk_hms("restart_no_commit", 8'h10, 8'h20, 8'h30);
        byte_rtc(8'h42, 8'h02, 1'b0);
        byte_rtc(8'h43, 8'h03, 1'b0);
        idle(1);
        chk_hms("restart_commit", 8'h03, 8'h02, 8'h01);
        idle(1);

        // Asynchronous reset in the middle of a frame.
        byte_rtc(8'h41, 8'h11, 1'b0);
        byte_rtc(8'h42, 8'h22, 1'b0);
        reset = 1'b0;
        #1;
        chk_hms("async_reset", 8'h00, 8'h00, 8'h00);
        idle(1);
        reset = 1'b1;
        byte_rtc(8'h43, 8'h33, 1'b0);
        idle(3);
        chk_hms("reset_lost_frame", 8'h00, 8'h00, 8'h00);

        idle(2);
        chk("commits_all_seen", exp_q.size(), 32'd0);
        report();
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        report();
        $fatal(1, "watchdog expired");
    end

endmodule
